// File: rtl/apb_master.sv
// APB master bridge: takes one command at a time, runs the APB SETUP/ACCESS
// handshake and returns a registered response with optional ACCESS timeout.
module apb_master #(
  parameter int          AWIDTH  = 10,
  parameter logic [2:0]  DSIZE   = 3'd2,
  parameter int          TIMEOUT = 16,
  localparam int         DBYTES  = 1 << DSIZE,
  localparam int         DWIDTH  = DBYTES * 8
) (
  input  logic              pclk,
  input  logic              presetn,
  // command
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [AWIDTH-1:0] cmd_addr,
  input  logic [DWIDTH-1:0] cmd_wdata,
  input  logic [DBYTES-1:0] cmd_strb,
  input  logic [2:0]        cmd_prot,
  // response
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_rdata,
  output logic              rsp_err,
  // APB
  output logic              psel,
  output logic              penable,
  output logic [2:0]        pprot,
  output logic              pwrite,
  output logic [AWIDTH-1:0] paddr,
  output logic [DBYTES-1:0] pstrb,
  output logic [DWIDTH-1:0] pwdata,
  input  logic [DWIDTH-1:0] prdata,
  input  logic              pready,
  input  logic              pslverr
);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

  localparam logic [AWIDTH-1:0] ADDR_MASK = ~AWIDTH'(DBYTES - 1);
  localparam logic [15:0]       TO_LIMIT  = 16'(TIMEOUT);

  state_t      state, next_state;
  logic [15:0] cnt;
  logic        accept;
  logic        timeout_hit;

  assign accept      = (state == IDLE) && cmd_valid && cmd_ready;
  // The final ACCESS cycle is the one where the counter would reach the limit.
  assign timeout_hit = (TIMEOUT != 0) && ((cnt + 16'd1) == TO_LIMIT);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) state <= IDLE;
    else          state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (accept)                 next_state = SETUP;
      SETUP:                               next_state = ACCESS;
      ACCESS:  if (pready || timeout_hit)  next_state = RESP;
      RESP:    if (rsp_ready)              next_state = IDLE;
      default:                             next_state = IDLE;
    endcase
  end

  // All interface outputs are registered; pready wins over a coincident timeout.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      cmd_ready <= 1'b0;
      psel      <= 1'b0;
      penable   <= 1'b0;
      pprot     <= '0;
      pwrite    <= 1'b0;
      paddr     <= '0;
      pstrb     <= '0;
      pwdata    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
      cnt       <= '0;
    end else begin
      cmd_ready <= (next_state == IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            paddr   <= cmd_addr & ADDR_MASK;
            pwrite  <= cmd_write;
            pprot   <= cmd_prot;
            pwdata  <= cmd_wdata;
            pstrb   <= cmd_write ? cmd_strb : '0;
            psel    <= 1'b1;
            penable <= 1'b0;
            cnt     <= '0;
          end
        end
        SETUP: penable <= 1'b1;
        ACCESS: begin
          if (pready) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= pslverr;
            rsp_rdata <= pwrite ? '0 : prdata;
          end else if (timeout_hit) begin
            psel      <= 1'b0;
            penable   <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_rdata <= '0;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
        RESP: if (rsp_ready) rsp_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter AWIDTH, default 10, address width in bits.
REQ-002 SHALL have parameter DSIZE [2:0], default 2, data size of 2^DSIZE bytes.
REQ-003 SHALL have parameter TIMEOUT, default 16, maximum ACCESS cycles (0 = no timeout, range 0..65535).
REQ-004 SHALL have hidden parameters DBYTES = 1<<DSIZE and DWIDTH = DBYTES*8.
REQ-005 SHALL use one clock and an asynchronous, active-low reset: pclk  in  1  clock; presetn  in  1  async active-low reset.
REQ-006 SHALL have these command ports: cmd_valid in 1 request; cmd_ready out 1 accept; cmd_write in 1 write=1; cmd_addr in AWIDTH byte address; cmd_wdata in DWIDTH write data; cmd_strb in DBYTES write strobes; cmd_prot in 3 protection.
REQ-007 SHALL have these response ports: rsp_valid out 1 response; rsp_ready in 1 response accept; rsp_rdata out DWIDTH read data; rsp_err out 1 error (pslverr or timeout).
REQ-008 SHALL have these APB ports: psel out 1; penable out 1; pprot out 3; pwrite out 1; paddr out AWIDTH; pstrb out DBYTES; pwdata out DWIDTH; prdata in DWIDTH; pready in 1; pslverr in 1.

Function
REQ-009 SHALL implement FSM IDLE -> SETUP -> ACCESS -> RESP -> IDLE, with all APB and response outputs driven from registers.
REQ-010 SHALL assert cmd_ready only in IDLE; a command is accepted on cmd_valid and cmd_ready at edge N, and the FSM enters SETUP.
REQ-011 SHALL, at acceptance, register the command: paddr = cmd_addr with its low DSIZE bits cleared; pwrite, pprot and pwdata as given; pstrb = cmd_strb for writes and all zeros for reads.
REQ-012 SHALL drive psel=1, penable=0 in SETUP (cycle N+1), then enter ACCESS unconditionally.
REQ-013 SHALL drive psel=1, penable=1 in ACCESS and hold paddr, pwrite, pwdata, pstrb and pprot stable from SETUP until ACCESS ends.
REQ-014 SHALL end ACCESS on the edge where pready=1, then: psel=0, penable=0, rsp_valid=1, rsp_err=pslverr, rsp_rdata=prdata for reads and zero for writes; go to RESP.
REQ-015 SHALL count ACCESS cycles with a 16-bit counter cleared on SETUP entry; with TIMEOUT>0, if pready stays 0 for TIMEOUT consecutive ACCESS cycles, it SHALL end the transfer on that edge with rsp_err=1, rsp_rdata=0, psel=0 and penable=0.
REQ-016 SHALL give pready=1 priority on the same cycle the timeout would fire; the transfer then completes normally.
REQ-017 SHALL hold rsp_valid, rsp_rdata and rsp_err stable in RESP until rsp_ready=1, then clear rsp_valid and return to IDLE; back-to-back commands therefore cost at least 4 cycles each.
REQ-018 SHALL ignore prdata, pready and pslverr outside ACCESS.
REQ-019 SHALL, in IDLE, drive psel=0 and penable=0; paddr, pwrite, pwdata, pstrb and pprot hold their last values.
REQ-020 SHALL give minimum latency from command acceptance (edge N) to rsp_valid=1 of 3 cycles (pready=1 on the first ACCESS cycle).

Reset
REQ-021 SHALL, with presetn=0, immediately (asynchronously) force the state to IDLE and all outputs to zero except cmd_ready, and clear the counter.
REQ-022 SHALL drive cmd_ready=1 from the first edge after presetn deasserts.
REQ-023 SHALL, on reset during SETUP, ACCESS or RESP, abandon the transfer: psel and rsp_valid drop without completion and no response is produced.

Verification
REQ-024 Bench SHALL cover: read addr 0x013, pready=1 immediately, prdata=0xCAFEF00D -> paddr=0x010, pstrb=0, penable high for 1 cycle, rsp_valid at N+3 with rsp_rdata=0xCAFEF00D and rsp_err=0.
REQ-025 Bench SHALL cover: write 0x0A5A5A5A, strb=0x3, pready low for 3 ACCESS cycles -> signals stable for all 4 ACCESS cycles, rsp_rdata=0, rsp_err=0.
REQ-026 Bench SHALL cover: TIMEOUT=16, pready held 0 -> psel drops after exactly 16 ACCESS cycles, rsp_err=1; with pready=1 on the 16th cycle -> normal completion with rsp_err=pslverr.
REQ-027 Bench SHALL cover: pslverr=1 with pready=1 on a read -> rsp_err=1 and rsp_rdata=prdata; rsp_ready held 0 for 5 cycles -> response held and cmd_ready=0 throughout.
REQ-028 Bench SHALL cover: presetn pulsed low mid-ACCESS -> psel, penable and rsp_valid are 0 at once, and the next command proceeds normally.
